// File: rtl/pipeline_pkg.sv
// Shared constants and types for the instruction-fetch stage: the NOP
// encoding, the register-field bit positions, the PC increment and the
// fetch control FSM states.
package pipeline_pkg;

  localparam int INSTR_WIDTH    = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  localparam int PC_STEP = 4;

  // FILL: IF/ID holds a bubble; RUN: IF/ID holds a real instruction
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetchState_t;

endpackage

// File: rtl/inst_fetch_stage_if.sv
// Control inputs and IF/ID outputs of the fetch stage bundled as one bus.
// The slave side is the fetch stage itself; the master side is whatever
// drives hazard/branch control and consumes the IF/ID register.
interface inst_fetch_stage_if #(
  parameter int PC_WIDTH = 32
);
  import pipeline_pkg::*;

  logic                      inInstFetchStall;
  logic                      inInstFetchBranchTaken;
  logic [PC_WIDTH-1:0]       inInstFetchBranchTarget;
  logic                      inInstFetchFlush;

  logic [PC_WIDTH-1:0]       outInstFetchPc;
  logic [INSTR_WIDTH-1:0]    outInstFetchInstruction;
  logic [PC_WIDTH-1:0]       outInstFetchPcPlus4;
  logic                      outInstFetchValid;
  logic [REG_ADDR_WIDTH-1:0] outInstFetchRsReg;
  logic [REG_ADDR_WIDTH-1:0] outInstFetchRtReg;
  logic [REG_ADDR_WIDTH-1:0] outInstFetchRdReg;

  modport master (
    output inInstFetchStall, inInstFetchBranchTaken,
           inInstFetchBranchTarget, inInstFetchFlush,
    input  outInstFetchPc, outInstFetchInstruction, outInstFetchPcPlus4,
           outInstFetchValid, outInstFetchRsReg, outInstFetchRtReg,
           outInstFetchRdReg
  );

  modport slave (
    input  inInstFetchStall, inInstFetchBranchTaken,
           inInstFetchBranchTarget, inInstFetchFlush,
    output outInstFetchPc, outInstFetchInstruction, outInstFetchPcPlus4,
           outInstFetchValid, outInstFetchRsReg, outInstFetchRtReg,
           outInstFetchRdReg
  );

endinterface

// File: rtl/inst_memory.sv
// Word-addressed instruction ROM with a combinational read. The image is
// supplied as a flat parameter, word i occupying bits [32*i +: 32], so the
// contents are fixed at elaboration and the ROM is pure combinational logic.
module inst_memory
  import pipeline_pkg::*;
#(
  parameter int IMEM_DEPTH     = 64,
  parameter int IMEM_ADDR_BITS = 6,
  parameter logic [IMEM_DEPTH*INSTR_WIDTH-1:0] IMEM_INIT = '0
) (
  input  logic [IMEM_ADDR_BITS-1:0] i_addr,
  output logic [INSTR_WIDTH-1:0]    o_data
);

  logic [INSTR_WIDTH-1:0] w_rom [IMEM_DEPTH];

  for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_romWord
    assign w_rom[gi] = IMEM_INIT[gi*INSTR_WIDTH +: INSTR_WIDTH];
  end

  assign o_data = w_rom[i_addr];

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, reads
// the instruction ROM combinationally and loads the IF/ID register. Per
// clock edge the priority is reset > branch > stall > normal; a flush
// without a branch inserts a bubble while still advancing (or holding) PC.
// IF/ID validity is the FILL/RUN state of the control FSM.
module inst_fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                  PC_WIDTH       = 32,
  parameter int                  IMEM_DEPTH     = 64,
  parameter int                  IMEM_ADDR_BITS = 6,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter logic [IMEM_DEPTH*INSTR_WIDTH-1:0] IMEM_INIT = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  inst_fetch_stage_if.slave       fetchBus
);

  logic [PC_WIDTH-1:0]       r_pc;
  logic [PC_WIDTH-1:0]       r_pcPlus4;
  logic [INSTR_WIDTH-1:0]    r_instr;
  fetchState_t               r_state;

  logic [PC_WIDTH-1:0]       w_pcNext;
  logic [PC_WIDTH-1:0]       w_pcPlus4Next;
  logic [INSTR_WIDTH-1:0]    w_instrNext;
  fetchState_t               w_stateNext;

  logic [PC_WIDTH-1:0]       w_pcIncr;
  logic [PC_WIDTH-1:0]       w_branchPc;
  logic [IMEM_ADDR_BITS-1:0] w_romAddr;
  logic [INSTR_WIDTH-1:0]    w_romData;

  // PC+4 wraps naturally at 2^PC_WIDTH; branch targets are forced word aligned
  assign w_pcIncr   = r_pc + PC_WIDTH'(PC_STEP);
  assign w_branchPc = fetchBus.inInstFetchBranchTarget & ~PC_WIDTH'(3);

  // Byte-address bits [1:0] are ignored and upper bits dropped, so the
  // ROM index wraps modulo IMEM_DEPTH words
  assign w_romAddr = r_pc[IMEM_ADDR_BITS+1:2];

  inst_memory #(
    .IMEM_DEPTH     (IMEM_DEPTH),
    .IMEM_ADDR_BITS (IMEM_ADDR_BITS),
    .IMEM_INIT      (IMEM_INIT)
  ) u_instMemory (
    .i_addr (w_romAddr),
    .o_data (w_romData)
  );

  // Next PC, next IF/ID contents and next FSM state by branch > flush > stall > normal
  always_comb begin
    w_pcNext      = r_pc;
    w_pcPlus4Next = r_pcPlus4;
    w_instrNext   = r_instr;
    w_stateNext   = r_state;
    if (fetchBus.inInstFetchBranchTaken) begin
      w_pcNext      = w_branchPc;
      w_instrNext   = NOP_INSTR;
      w_pcPlus4Next = '0;
      w_stateNext   = FILL;
    end else if (fetchBus.inInstFetchFlush) begin
      if (!fetchBus.inInstFetchStall) begin
        w_pcNext = w_pcIncr;
      end
      w_instrNext   = NOP_INSTR;
      w_pcPlus4Next = '0;
      w_stateNext   = FILL;
    end else if (!fetchBus.inInstFetchStall) begin
      w_pcNext      = w_pcIncr;
      w_instrNext   = w_romData;
      w_pcPlus4Next = w_pcIncr;
      w_stateNext   = RUN;
    end
  end

  // PC, IF/ID register and FSM state, cleared asynchronously to a bubble at RESET_PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_pcPlus4 <= '0;
      r_instr   <= NOP_INSTR;
      r_state   <= FILL;
    end else begin
      r_pc      <= w_pcNext;
      r_pcPlus4 <= w_pcPlus4Next;
      r_instr   <= w_instrNext;
      r_state   <= w_stateNext;
    end
  end

  assign fetchBus.outInstFetchPc          = r_pc;
  assign fetchBus.outInstFetchInstruction = r_instr;
  assign fetchBus.outInstFetchPcPlus4     = r_pcPlus4;
  assign fetchBus.outInstFetchValid       = (r_state == RUN);
  assign fetchBus.outInstFetchRsReg       = r_instr[RS_MSB:RS_LSB];
  assign fetchBus.outInstFetchRtReg       = r_instr[RT_MSB:RT_LSB];
  assign fetchBus.outInstFetchRdReg       = r_instr[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage. A driver applies directed and
// random control patterns, advances a behavioural fetch model and queues the
// expected PC and IF/ID contents; a monitor pops and compares after each edge.
module tb_inst_fetch_stage;

  localparam int PCW   = 32;
  localparam int DEPTH = 64;

  function automatic logic [31:0] romWord(input int idx);
    if (idx == 0) return 32'h0022_1820;
    if (idx == 1) return 32'h8C43_0004;
    return (idx * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [DEPTH*32-1:0] buildRom();
    logic [DEPTH*32-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[i*32 +: 32] = romWord(i);
    return img;
  endfunction

  localparam logic [DEPTH*32-1:0] TB_ROM = buildRom();

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_stage_if #(.PC_WIDTH(PCW)) fetchBus ();

  inst_fetch_stage #(
    .PC_WIDTH       (PCW),
    .IMEM_DEPTH     (DEPTH),
    .IMEM_ADDR_BITS (6),
    .RESET_PC       (32'h0),
    .IMEM_INIT      (TB_ROM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fetchBus (fetchBus.slave)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcPlus4;
  } ifIdEntry_t;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelPc;
  logic        modelValid;
  logic [31:0] modelInstr;
  logic [31:0] modelPcPlus4;
  logic [31:0] pcQueue [$];
  ifIdEntry_t  ifIdQueue [$];
  bit          monitorEn = 1'b0;

  logic [31:0] monPc;
  ifIdEntry_t  monEntry;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=dut_output expected=none_queued at %0t", name, $time);
  endtask

  task automatic resetModel();
    modelPc      = 32'h0;
    modelValid   = 1'b0;
    modelInstr   = 32'h0;
    modelPcPlus4 = 32'h0;
    pcQueue.delete();
    ifIdQueue.delete();
  endtask

  // One clock edge of the fetch stage, written from the behavioural rules
  task automatic modelEdge(input bit stall, input bit br, input logic [31:0] tgt, input bit flush);
    ifIdEntry_t e;
    if (br) begin
      modelPc    = tgt & 32'hFFFF_FFFC;
      modelValid = 1'b0;
      modelInstr = 32'h0;
    end else if (flush) begin
      if (!stall) modelPc = modelPc + 32'd4;
      modelValid = 1'b0;
      modelInstr = 32'h0;
    end else if (!stall) begin
      modelInstr   = romWord(int'((modelPc / 32'd4) % 32'd64));
      modelPcPlus4 = modelPc + 32'd4;
      modelValid   = 1'b1;
      modelPc      = modelPc + 32'd4;
    end
    pcQueue.push_back(modelPc);
    if (modelValid) begin
      e.instr   = modelInstr;
      e.pcPlus4 = modelPcPlus4;
      ifIdQueue.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit stall, input bit br, input logic [31:0] tgt, input bit flush);
    fetchBus.inInstFetchStall        = stall;
    fetchBus.inInstFetchBranchTaken  = br;
    fetchBus.inInstFetchBranchTarget = tgt;
    fetchBus.inInstFetchFlush        = flush;
    @(posedge clk);
    #1;
    modelEdge(stall, br, tgt, flush);
  endtask

  // Monitor: after every edge compare PC, and IF/ID whenever it is presented as valid
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (monitorEn) begin
        if (pcQueue.size() == 0) begin
          reportMissing("pc_queue_underflow");
        end else begin
          monPc = pcQueue.pop_front();
          checkOutput("pc", fetchBus.outInstFetchPc, monPc);
        end
        if (fetchBus.outInstFetchValid) begin
          if (ifIdQueue.size() == 0) begin
            reportMissing("ifid_unexpected_valid");
          end else begin
            monEntry = ifIdQueue.pop_front();
            checkOutput("ifid_instr", fetchBus.outInstFetchInstruction, monEntry.instr);
            checkOutput("ifid_pcplus4", fetchBus.outInstFetchPcPlus4, monEntry.pcPlus4);
            checkOutput("ifid_rs", {27'b0, fetchBus.outInstFetchRsReg}, (monEntry.instr >> 21) & 32'h1F);
            checkOutput("ifid_rt", {27'b0, fetchBus.outInstFetchRtReg}, (monEntry.instr >> 16) & 32'h1F);
            checkOutput("ifid_rd", {27'b0, fetchBus.outInstFetchRdReg}, (monEntry.instr >> 11) & 32'h1F);
          end
        end else begin
          checkOutput("bubble_instr", fetchBus.outInstFetchInstruction, 32'h0);
        end
      end
    end
  end

  initial begin
    int r;
    logic [31:0] tgt;
    fetchBus.inInstFetchStall        = 1'b0;
    fetchBus.inInstFetchBranchTaken  = 1'b0;
    fetchBus.inInstFetchBranchTarget = 32'h0;
    fetchBus.inInstFetchFlush        = 1'b0;

    // Reset takes effect without a clock edge
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_pc", fetchBus.outInstFetchPc, 32'h0);
    checkOutput("reset_valid", {31'b0, fetchBus.outInstFetchValid}, 32'h0);
    checkOutput("reset_instr", fetchBus.outInstFetchInstruction, 32'h0);
    checkOutput("reset_pcplus4", fetchBus.outInstFetchPcPlus4, 32'h0);
    checkOutput("reset_rs", {27'b0, fetchBus.outInstFetchRsReg}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    resetModel();
    monitorEn = 1'b1;

    // Free-run the first two words
    applyStimulus(0, 0, 32'h0, 0); #1;
    checkOutput("run1_instr", fetchBus.outInstFetchInstruction, 32'h0022_1820);
    checkOutput("run1_rs", {27'b0, fetchBus.outInstFetchRsReg}, 32'd1);
    checkOutput("run1_rt", {27'b0, fetchBus.outInstFetchRtReg}, 32'd2);
    checkOutput("run1_rd", {27'b0, fetchBus.outInstFetchRdReg}, 32'd3);
    checkOutput("run1_pcplus4", fetchBus.outInstFetchPcPlus4, 32'd4);
    checkOutput("run1_valid", {31'b0, fetchBus.outInstFetchValid}, 32'd1);
    applyStimulus(0, 0, 32'h0, 0); #1;
    checkOutput("run2_instr", fetchBus.outInstFetchInstruction, 32'h8C43_0004);
    checkOutput("run2_pcplus4", fetchBus.outInstFetchPcPlus4, 32'd8);
    checkOutput("run2_pc", fetchBus.outInstFetchPc, 32'd8);

    // Three-cycle stall holds PC and IF/ID
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 32'h0, 0); #1;
      checkOutput("stall_pc", fetchBus.outInstFetchPc, 32'd8);
      checkOutput("stall_instr", fetchBus.outInstFetchInstruction, 32'h8C43_0004);
      checkOutput("stall_pcplus4", fetchBus.outInstFetchPcPlus4, 32'd8);
    end
    applyStimulus(0, 0, 32'h0, 0); #1;
    checkOutput("resume_instr", fetchBus.outInstFetchInstruction, romWord(2));
    checkOutput("resume_pc", fetchBus.outInstFetchPc, 32'h0C);

    // Taken branch from 0x0C to 0x20
    applyStimulus(0, 1, 32'h20, 0); #1;
    checkOutput("branch_pc", fetchBus.outInstFetchPc, 32'h20);
    checkOutput("branch_valid", {31'b0, fetchBus.outInstFetchValid}, 32'd0);
    checkOutput("branch_instr", fetchBus.outInstFetchInstruction, 32'h0);
    applyStimulus(0, 0, 32'h0, 0); #1;
    checkOutput("target_instr", fetchBus.outInstFetchInstruction, romWord(8));
    checkOutput("target_pcplus4", fetchBus.outInstFetchPcPlus4, 32'h24);

    // Branch beats stall, target low bits cleared
    applyStimulus(1, 1, 32'h13, 0); #1;
    checkOutput("brstall_pc", fetchBus.outInstFetchPc, 32'h10);
    checkOutput("brstall_valid", {31'b0, fetchBus.outInstFetchValid}, 32'd0);

    // Flush alone advances PC and inserts a bubble
    applyStimulus(0, 0, 32'h0, 1); #1;
    checkOutput("flush_pc", fetchBus.outInstFetchPc, 32'h14);
    checkOutput("flush_valid", {31'b0, fetchBus.outInstFetchValid}, 32'd0);

    // Random control mix, including targets near the top of the address space
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0)      tgt = $urandom;
      else if (r == 1) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else             tgt = 32'($urandom_range(0, 511));
      applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, tgt,
                    $urandom_range(0, 99) < 8);
    end

    // ROM index wrap past the last word
    applyStimulus(0, 1, 32'hFC, 0);
    applyStimulus(0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0); #1;
    checkOutput("wrap_instr", fetchBus.outInstFetchInstruction, 32'h0022_1820);
    checkOutput("wrap_pcplus4", fetchBus.outInstFetchPcPlus4, 32'h104);
    checkOutput("wrap_valid", {31'b0, fetchBus.outInstFetchValid}, 32'd1);

    // Asynchronous reset in the middle of a stall at 0x30
    applyStimulus(0, 1, 32'h30, 0);
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0);
    #1;
    monitorEn = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midreset_pc", fetchBus.outInstFetchPc, 32'h0);
    checkOutput("midreset_valid", {31'b0, fetchBus.outInstFetchValid}, 32'd0);
    checkOutput("midreset_instr", fetchBus.outInstFetchInstruction, 32'h0);
    checkOutput("midreset_pcplus4", fetchBus.outInstFetchPcPlus4, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    resetModel();
    monitorEn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom_range(0, 99) < 25, 1'b0, 32'h0, 1'b0);
    end

    #4;
    monitorEn = 1'b0;
    checkOutput("pc_queue_drained", 32'(pcQueue.size()), 32'd0);
    checkOutput("ifid_queue_drained", 32'(ifIdQueue.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
